uart_tx_arbiter: RTL and testbench

Shares one UART transmitter FIFO (`uart_tx6`) between `NUM_REQ` byte-stream requesters, e.g. several PicoBlaze port-mapped sources or hardware message generators. Grants are message-atomic: a requester keeps the transmitter from its first byte through the byte flagged `last`, so messages never interleave on TX. Grant order is round-robin. A watchdog releases a requester that stalls mid-message. The block sits between the requesters and the `data_in`/`buffer_write`/`buffer_full` pins of `uart_tx6`.

---
 rtl/uart_arb_pkg.sv | 38 +++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_arb_pkg
//  Purpose  : Shared types and helpers for the UART TX arbiter: FSM state
//             encoding, watchdog width and the round-robin pick function.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int WD_W    = 16;
  localparam int MAX_REQ = 8;

  // First set bit of 'valid' at or above 'ptr', wrapping modulo n; one-hot.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                  input logic [2:0]         ptr,
                                                  input int                 n);
    logic [MAX_REQ-1:0] choice;
    logic               found;
    int                 slot;
    choice = '0;
    found  = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      slot = (int'(ptr) + k) % n;
      if ((k < n) && !found && valid[slot[2:0]]) begin
        choice[slot[2:0]] = 1'b1;
        found             = 1'b1;
      end
    end
    return choice;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Round-robin requester selection. Produces a combinational
//             one-hot pick and owns the priority pointer, which moves just
//             past the departing owner whenever a grant is released.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               advance,
  input  logic [PTR_W-1:0]   owner,
  output logic [NUM_REQ-1:0] pick
);

  logic [PTR_W-1:0]   rr_ptr;
  logic [MAX_REQ-1:0] pick_full;
  logic               unused_pick;

  // Search upward from the pointer, wrapping, for the first valid requester.
  always_comb begin
    pick_full = rr_pick(MAX_REQ'(req_valid), 3'(rr_ptr), NUM_REQ);
  end

  assign pick        = pick_full[NUM_REQ-1:0];
  assign unused_pick = ^pick_full;

  // Pointer register: on release, the requester after the owner gets priority.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Message-atomic round-robin sharing of one uart_tx6 FIFO among
//             NUM_REQ byte streams, with a watchdog that revokes a grant
//             when the owner stalls mid-message.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  input  logic                 tx_full,
  output logic [7:0]           tx_data,
  output logic                 tx_write,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int              PTR_W    = $clog2(NUM_REQ);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [NUM_REQ-1:0] pick;
  logic [WD_W-1:0]    wd, wd_nxt;
  logic               to_nxt;
  logic               advance;
  logic [PTR_W-1:0]   owner;
  logic               own_valid;
  logic               own_last;
  logic [7:0]         own_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .advance   (advance),
    .owner     (owner),
    .pick      (pick)
  );

  // Decode the one-hot grant into an index and select the owner's stream.
  always_comb begin
    owner     = '0;
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        owner     = PTR_W'(i);
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[8*i +: 8];
      end
    end
  end

  // Next-state, watchdog and ready/write gating; writes are never issued
  // while the FIFO reports full, so it cannot overflow.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    wd_nxt    = wd;
    to_nxt    = 1'b0;
    advance   = 1'b0;
    req_ready = '0;
    tx_write  = 1'b0;
    tx_data   = 8'h00;
    case (state)
      ST_IDLE: begin
        if (|req_valid) begin
          grant_nxt = pick;
          wd_nxt    = '0;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        req_ready = grant & {NUM_REQ{~tx_full}};
        if (own_valid && !tx_full) begin
          tx_write = 1'b1;
          tx_data  = own_data;
          wd_nxt   = '0;
          if (own_last) begin
            state_nxt = ST_IDLE;
            grant_nxt = '0;
            advance   = 1'b1;
          end
        end else if (!own_valid) begin
          // Blocked-by-full cycles fall through here untouched: wd holds.
          if (wd == WD_LIMIT) begin
            state_nxt = ST_IDLE;
            grant_nxt = '0;
            wd_nxt    = '0;
            advance   = 1'b1;
            to_nxt    = 1'b1;
          end else begin
            wd_nxt = wd + WD_W'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // State, grant, watchdog and timeout pulse registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      grant       <= '0;
      wd          <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      wd          <= wd_nxt;
      timeout_err <= to_nxt;
    end
  end

  assign busy = (state == ST_BUSY);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Purpose  : Self-checking bench for uart_tx_arbiter. Requester drivers push
//             each byte into a per-requester expectation queue as they
//             queue it; a negedge monitor checks every write, grant choice,
//             ready gating and watchdog pulse against a spec-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 4;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last = '0;
  logic [8*N-1:0] req_data = '0;
  logic           tx_full = 1'b0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic [7:0]     tx_data;
  logic           tx_write;
  logic           busy;
  logic           timeout_err;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .grant       (grant),
    .tx_full     (tx_full),
    .tx_data     (tx_data),
    .tx_write    (tx_write),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    n_chk = 0;
  int    n_fail = 0;
  beat_t drv_q[N][$];
  beat_t exp_q[N][$];
  int    own_log[$];
  int    wr_log[$];
  int    grant_cycle = 0;
  int    to_count = 0;
  bit    stall_en = 0, rand_full = 0, forced_full = 0, bp_chk = 0;
  int    stall_cnt[N] = '{default: 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Round-robin rule: first valid requester at or after p, wrapping.
  function automatic logic [N-1:0] pick_model(input logic [N-1:0] v, input int p);
    logic [N-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++)
      if (r == '0 && v[(p + k) % N]) r[(p + k) % N] = 1'b1;
    return r;
  endfunction

  function automatic int idx_of(input logic [N-1:0] g);
    int r;
    r = 0;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int           ptr_m = 0;
  logic [N-1:0] prev_grant = '0, prev_valid = '0, exp_g = '0;
  int           idle_cnt = 0, m_g = 0;
  bit           exp_to = 0, exp_gchk = 0, to_now = 0, m_expwr = 0;
  beat_t        m_e;

  always @(negedge clk) begin
    if (!reset) begin
      ptr_m = 0; prev_grant = '0; prev_valid = '0;
      idle_cnt = 0; exp_to = 0; exp_gchk = 0;
    end else begin
      chk("timeout_err", 32'(timeout_err), 32'(exp_to));
      if (timeout_err) to_count++;
      if (exp_to) chk("grant_after_timeout", 32'(grant), 0);
      if (exp_gchk) chk("grant_after_byte", 32'(grant), 32'(exp_g));
      if (prev_grant != '0 && grant == '0) ptr_m = (idx_of(prev_grant) + 1) % N;
      if (prev_grant == '0) begin
        chk("grant_pick", 32'(grant), 32'(pick_model(prev_valid, ptr_m)));
        if (grant != '0) begin
          own_log.push_back(idx_of(grant));
          grant_cycle = cyc;
          idle_cnt = 0;
        end
      end else if (grant != '0) begin
        chk("grant_hold", 32'(grant), 32'(prev_grant));
      end
      chk("busy", 32'(busy), 32'(grant != '0));
      chk("req_ready", 32'(req_ready), tx_full ? 32'd0 : 32'(grant));
      m_expwr = 0;
      m_g = idx_of(grant);
      if (grant != '0) m_expwr = req_valid[m_g] && !tx_full;
      chk("tx_write", 32'(tx_write), 32'(m_expwr));
      to_now = 0;
      exp_gchk = 0;
      if (tx_write && grant != '0) begin
        wr_log.push_back(cyc);
        idle_cnt = 0;
        if (exp_q[m_g].size() == 0) begin
          chk("unexpected_byte", 32'(exp_q[m_g].size()), 1);
        end else begin
          m_e = exp_q[m_g].pop_front();
          chk("tx_data", 32'(tx_data), 32'(m_e.d));
          exp_gchk = 1;
          exp_g = m_e.l ? '0 : grant;
        end
      end else if (grant != '0 && !req_valid[m_g]) begin
        idle_cnt++;
        if (idle_cnt == TO) to_now = 1;
      end
      exp_to = to_now;
      prev_grant = grant;
      prev_valid = req_valid;
    end
  end

  // ---------------- drivers ----------------
  task automatic drive();
    bit st;
    for (int i = 0; i < N; i++) begin
      st = 0;
      if (stall_en && drv_q[i].size() > 0 && stall_cnt[i] < 2 && $urandom_range(0, 3) == 0) begin
        st = 1;
        stall_cnt[i]++;
      end else begin
        stall_cnt[i] = 0;
      end
      if (drv_q[i].size() > 0 && !st) begin
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = drv_q[i][0].d;
        req_last[i] = drv_q[i][0].l;
      end else begin
        req_valid[i] = 1'b0;
        req_data[8*i +: 8] = 8'($urandom);
        req_last[i] = 1'($urandom);
      end
    end
    tx_full = forced_full | (rand_full && $urandom_range(0, 4) == 0);
  endtask

  task automatic step();
    logic [N-1:0] hs;
    @(negedge clk);
    hs = req_valid & req_ready;
    if (bp_chk) begin
      chk("bp_ready", 32'(req_ready), 0);
      chk("bp_write", 32'(tx_write), 0);
      chk("bp_wd", 32'(dut.wd), 0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (hs[i]) void'(drv_q[i].pop_front());
    drive();
  endtask

  task automatic enq(input int i, input int len, input int base, input bit term);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.d = (base < 0) ? 8'($urandom) : 8'(base + k);
      b.l = term && (k == len - 1);
      drv_q[i].push_back(b);
      exp_q[i].push_back(b);
    end
  endtask

  function automatic bit all_idle();
    bit r;
    r = (busy == 1'b0);
    for (int i = 0; i < N; i++) if (drv_q[i].size() != 0) r = 0;
    return r;
  endfunction

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (!all_idle() && n < bound) begin
      step();
      n++;
    end
    chk("drain_bound", 32'(n < bound), 1);
  endtask

  task automatic rst_outputs(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_tx_write"}, 32'(tx_write), 0);
    chk({tag, "_tx_data"}, 32'(tx_data), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int vc, to0, sent, n;
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Contention from reset: req0 wins, then req2.
    own_log.delete();
    enq(0, 2, 'h0a, 1);
    enq(2, 2, 'h2a, 1);
    drive();
    drain(200);
    chk("cont_count", 32'(own_log.size()), 2);
    if (own_log.size() == 2) begin
      chk("cont_first", 32'(own_log[0]), 0);
      chk("cont_second", 32'(own_log[1]), 2);
    end

    // Single requester: 41,42,43 written on the three cycles after grant.
    own_log.delete();
    wr_log.delete();
    vc = cyc;
    enq(1, 3, 'h41, 1);
    drive();
    drain(200);
    chk("single_grant_latency", 32'(grant_cycle), 32'(vc + 1));
    chk("single_writes", 32'(wr_log.size()), 3);
    if (wr_log.size() == 3)
      for (int k = 0; k < 3; k++) chk("single_write_cycle", 32'(wr_log[k]), 32'(vc + 1 + k));
    chk("single_owner", 32'(own_log.size() > 0 ? own_log[0] : -1), 1);

    // Fairness: pointer sits at 2 after req1; rotation 2,3,0,1,2,3,0,1.
    own_log.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) enq(i, 1, -1, 1);
    drive();
    drain(200);
    chk("fair_count", 32'(own_log.size()), 8);
    if (own_log.size() == 8)
      for (int k = 0; k < 8; k++) chk("fair_order", 32'(own_log[k]), 32'((2 + k) % N));

    // Backpressure: 5 full cycles mid-message.
    wr_log.delete();
    enq(3, 4, -1, 1);
    drive();
    n = 0;
    while (wr_log.size() == 0 && n < 20) begin
      step();
      n++;
    end
    chk("bp_first_write", 32'(wr_log.size() > 0), 1);
    forced_full = 1;
    drive();
    bp_chk = 1;
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) forced_full = 0;
      step();
    end
    bp_chk = 0;
    drain(200);

    // Watchdog: req1 sends one non-final byte, then stops.
    to0 = to_count;
    own_log.delete();
    enq(1, 1, -1, 0);
    drive();
    n = 0;
    while (drv_q[1].size() != 0 && n < 20) begin
      step();
      n++;
    end
    enq(0, 2, -1, 1);
    enq(2, 2, -1, 1);
    drive();
    drain(300);
    chk("to_pulses", 32'(to_count - to0), 1);
    chk("to_count_grants", 32'(own_log.size()), 3);
    if (own_log.size() == 3) chk("to_next_owner", 32'(own_log[1]), 2);

    // Randomized traffic with stalls and random FIFO-full.
    stall_en = 1;
    rand_full = 1;
    sent = 0;
    n = 0;
    while ((sent < 150 || !all_idle()) && n < 20000) begin
      if (sent < 150 && $urandom_range(0, 2) == 0) begin
        enq(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 5)), -1, 1);
        sent++;
      end
      step();
      n++;
    end
    chk("random_bound", 32'(n < 20000), 1);
    stall_en = 0;
    rand_full = 0;

    // Reset mid-message.
    enq(2, 6, -1, 1);
    drive();
    n = 0;
    while (!(grant[2] && drv_q[2].size() < 6) && n < 50) begin
      step();
      n++;
    end
    chk("mid_reset_busy", 32'(busy), 1);
    step();
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      drv_q[i].delete();
      exp_q[i].delete();
    end
    drive();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    rst_outputs("mid_reset");
    @(posedge clk);
    #1;
    own_log.delete();
    enq(3, 1, -1, 1);
    enq(0, 1, -1, 1);
    drive();
    drain(200);
    chk("post_reset_count", 32'(own_log.size()), 2);
    if (own_log.size() == 2) chk("post_reset_first", 32'(own_log[0]), 0);

    for (int i = 0; i < N; i++) chk("exp_drained", 32'(exp_q[i].size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule
`default_nettype wire
